// File: rtl/aqp_spi_msg_master.sv
// aqp_spi_msg_master: SPI mode-0, MSB-first master that sends framed messages.
// A message is one SSEL-low window. Its first byte is the command and the
// remaining bytes are data. Every byte shifted out returns one byte from MISO.
//
// Ports:
//   clk, reset              system clock, asynchronous active-low reset
//   tx_data/tx_last         byte to send and end-of-message flag, sampled on accept
//   tx_valid/tx_ready       byte handshake
//   rx_data/rx_valid        received byte, one-cycle pulse per transmitted byte
//   busy                    high whenever the master is not idle
//   msg_done                one-cycle pulse in the cycle SSEL returns high
//   spi_ssel_n/spi_sclk/spi_mosi/spi_miso   SPI pins (SCLK idles low)
module aqp_spi_msg_master #(
  parameter int unsigned CLKDIV   = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_GAP   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       msg_done,
  output logic       spi_ssel_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSetup = 3'd1;
  localparam logic [2:0] StShift = 3'd2;
  localparam logic [2:0] StNext  = 3'd3;
  localparam logic [2:0] StHold  = 3'd4;
  localparam logic [2:0] StGap   = 3'd5;

  localparam int unsigned DivW  = $clog2(CLKDIV) + 1;
  localparam int unsigned MaxCs = (CS_SETUP > CS_HOLD) ?
                                  ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP) :
                                  ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
  localparam int unsigned CntW  = $clog2(MaxCs + 1);

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DivW-1:0] div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  // Bits still to be sent after the one currently on MOSI (byte bits 6..0).
  logic [6:0]      tx_sh_q, tx_sh_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic            last_q, last_d;
  logic            sclk_q, sclk_d;
  logic            ssel_n_q, ssel_n_d;
  logic            mosi_q, mosi_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            msg_done_q, msg_done_d;
  logic            miso_s1_q, miso_s2_q;

  logic accept;
  logic div_tc;

  assign tx_ready   = reset & ((state_q == StIdle) | (state_q == StNext));
  assign accept     = tx_valid & tx_ready;
  assign div_tc     = (div_q == DivW'(CLKDIV - 1));
  assign busy       = (state_q != StIdle);
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign msg_done   = msg_done_q;
  assign spi_ssel_n = ssel_n_q;
  assign spi_sclk   = sclk_q;
  assign spi_mosi   = mosi_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    bit_d      = bit_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    last_d     = last_q;
    sclk_d     = 1'b0;
    mosi_d     = mosi_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    msg_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          tx_sh_d = tx_data[6:0];
          mosi_d  = tx_data[7];
          last_d  = tx_last;
          bit_d   = 3'd0;
          cnt_d   = '0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == CntW'(CS_SETUP - 1)) begin
          div_d   = '0;
          state_d = StShift;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StShift: begin
        sclk_d = sclk_q;
        if (div_tc) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            rx_sh_d = {rx_sh_q[6:0], miso_s2_q};
            bit_d   = bit_q + 3'd1;
          end else if (bit_q != 3'd0) begin
            mosi_d  = tx_sh_q[6];
            tx_sh_d = {tx_sh_q[5:0], 1'b0};
          end else begin
            // Counter wrapped after 8 rises: this is the byte's last falling edge.
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
            cnt_d      = '0;
            state_d    = last_q ? StHold : StNext;
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StNext: begin
        if (accept) begin
          tx_sh_d = tx_data[6:0];
          mosi_d  = tx_data[7];
          last_d  = tx_last;
          bit_d   = 3'd0;
          div_d   = '0;
          state_d = StShift;
        end
      end
      StHold: begin
        if (cnt_q == CntW'(CS_HOLD - 1)) begin
          msg_done_d = 1'b1;
          mosi_d     = 1'b0;
          cnt_d      = '0;
          state_d    = StGap;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q == CntW'(CS_GAP - 1)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    ssel_n_d = (state_d == StIdle) || (state_d == StGap);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      div_q      <= '0;
      bit_q      <= 3'd0;
      tx_sh_q    <= 7'd0;
      rx_sh_q    <= 8'd0;
      last_q     <= 1'b0;
      sclk_q     <= 1'b0;
      ssel_n_q   <= 1'b1;
      mosi_q     <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      msg_done_q <= 1'b0;
      miso_s1_q  <= 1'b0;
      miso_s2_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      last_q     <= last_d;
      sclk_q     <= sclk_d;
      ssel_n_q   <= ssel_n_d;
      mosi_q     <= mosi_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      msg_done_q <= msg_done_d;
      miso_s1_q  <= spi_miso;
      miso_s2_q  <= miso_s1_q;
    end
  end

endmodule

// File: tb/tb_aqp_spi_msg_master.sv
// Bench for aqp_spi_msg_master (CLKDIV=2). Stimulus pushes expected received
// bytes and expected frames into queues; a monitor pops them when the DUT
// pulses rx_valid or msg_done. A slave model echoes the previous byte of the
// frame (0x00 first) and records everything it sees on MOSI.
module tb_aqp_spi_msg_master;

  localparam int unsigned CLKDIV   = 2;
  localparam int unsigned CS_SETUP = 2;
  localparam int unsigned CS_HOLD  = 2;
  localparam int unsigned CS_GAP   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'd0;
  logic       tx_last = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       msg_done;
  logic       spi_ssel_n;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;

  aqp_spi_msg_master #(
    .CLKDIV  (CLKDIV),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD),
    .CS_GAP  (CS_GAP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_last   (tx_last),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .msg_done  (msg_done),
    .spi_ssel_n(spi_ssel_n),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         n;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         low;
  } frame_t;

  frame_t     exp_frames[$];
  logic [7:0] exp_rx[$];

  function automatic int lowt(input int n, input int stall);
    return CS_SETUP + n * 16 * CLKDIV + (n - 1) + CS_HOLD + stall;
  endfunction

  task automatic push_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int low);
    frame_t f;
    f.n = n; f.b0 = b0; f.b1 = b1; f.b2 = b2; f.low = low;
    exp_frames.push_back(f);
  endtask

  // Slave model: output register advances right after it samples MOSI, which
  // leaves MISO settled well ahead of the master's two-flop synchroniser.
  logic [7:0] s_out = 8'd0;
  logic [7:0] s_in = 8'd0;
  int         s_bit = 0;
  logic [7:0] s_frame[$];
  logic       s_ssel_prev = 1'b1;
  logic       s_sclk_prev = 1'b0;
  logic       miso_one = 1'b0;

  assign spi_miso = miso_one | s_out[7];

  always @(negedge clk) begin
    if (s_ssel_prev && !spi_ssel_n) begin
      s_out = 8'd0;
      s_bit = 0;
      s_frame.delete();
    end
    if (!s_sclk_prev && spi_sclk && !spi_ssel_n) begin
      s_in = {s_in[6:0], spi_mosi};
      if (s_bit == 7) begin
        s_frame.push_back(s_in);
        s_out = s_in;
        s_bit = 0;
      end else begin
        s_out = {s_out[6:0], 1'b0};
        s_bit++;
      end
    end
    s_ssel_prev = spi_ssel_n;
    s_sclk_prev = spi_sclk;
  end

  // Monitor / scoreboard.
  int low_cnt = 0;
  always @(negedge clk) begin
    frame_t     f;
    logic [7:0] e;
    if (!spi_ssel_n) low_cnt++;
    if (spi_sclk && spi_ssel_n) check("sclk_outside_frame", 32'(spi_sclk), 32'd0);
    if (rx_valid) begin
      check("rx_valid_in_frame", 32'(spi_ssel_n), 32'd0);
      if (exp_rx.size() == 0) begin
        total++; bad++;
        $display("FAIL rx_unexpected: got %02h expected no byte", rx_data);
      end else begin
        e = exp_rx.pop_front();
        check("rx_data", 32'(rx_data), 32'(e));
      end
    end
    if (msg_done) begin
      if (exp_frames.size() == 0) begin
        total++; bad++;
        $display("FAIL msg_done_unexpected: got pulse expected none");
      end else begin
        f = exp_frames.pop_front();
        check("ssel_low_time", 32'(low_cnt), 32'(f.low));
        check("frame_len", 32'(s_frame.size()), 32'(f.n));
        if (s_frame.size() > 0) check("frame_cmd", 32'(s_frame[0]), 32'(f.b0));
        if (f.n > 1 && s_frame.size() > 1) check("frame_b1", 32'(s_frame[1]), 32'(f.b1));
        if (f.n > 2 && s_frame.size() > 2) check("frame_b2", 32'(s_frame[2]), 32'(f.b2));
      end
    end
    if (spi_ssel_n) low_cnt = 0;
  end

  task automatic send(input logic [7:0] d, input logic last);
    int n = 0;
    tx_data = d; tx_last = last; tx_valid = 1'b1;
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("tx_accept_seen", 32'(tx_ready), 32'd1);
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!msg_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("msg_done_seen", 32'(msg_done), 32'd1);
  endtask

  task automatic wait_rx();
    int n = 0;
    @(negedge clk);
    while (!rx_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("rx_valid_seen", 32'(rx_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rises;
    int hi;
    int stall_bad;
    logic prev;

    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ssel_n", 32'(spi_ssel_n), 32'd1);
    check("rst_sclk", 32'(spi_sclk), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_msg_done", 32'(msg_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_tx_ready", 32'(tx_ready), 32'd1);

    // Single byte, MISO held high.
    miso_one = 1'b1;
    push_frame(1, 8'hA5, 8'h00, 8'h00, lowt(1, 0));
    exp_rx.push_back(8'hFF);
    send(8'hA5, 1'b1);
    wait_done();
    n = 0;
    while (!tx_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("gap_tx_ready_low", 32'(n), 32'(CS_GAP));
    miso_one = 1'b0;

    // Three bytes back-to-back.
    push_frame(3, 8'h23, 8'h34, 8'h12, lowt(3, 0));
    exp_rx.push_back(8'h00); exp_rx.push_back(8'h23); exp_rx.push_back(8'h34);
    send(8'h23, 1'b0);
    send(8'h34, 1'b0);
    send(8'h12, 1'b1);
    wait_done();

    // Stall of 50 clocks before the second byte.
    @(negedge clk);
    push_frame(2, 8'h81, 8'h7E, 8'h00, lowt(2, 50));
    exp_rx.push_back(8'h00); exp_rx.push_back(8'h81);
    send(8'h81, 1'b0);
    wait_rx();
    stall_bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (spi_sclk || spi_ssel_n || rx_valid || !tx_ready || !busy) stall_bad++;
    end
    check("stall_lines", 32'(stall_bad), 32'd0);
    send(8'h7E, 1'b1);
    wait_done();

    // Reset during bit 4 of byte 2.
    @(negedge clk);
    exp_rx.push_back(8'h00);
    send(8'h5A, 1'b0);
    send(8'hC3, 1'b0);
    rises = 0; n = 0; prev = spi_sclk;
    while (rises < 4 && n < 500) begin
      @(negedge clk);
      if (spi_sclk && !prev) rises++;
      prev = spi_sclk;
      n++;
    end
    check("abort_reached_bit4", 32'(rises), 32'd4);
    #2 reset = 1'b0;
    #1;
    check("abort_ssel_n", 32'(spi_ssel_n), 32'd1);
    check("abort_sclk", 32'(spi_sclk), 32'd0);
    check("abort_mosi", 32'(spi_mosi), 32'd0);
    check("abort_tx_ready", 32'(tx_ready), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_rx_queue", 32'(exp_rx.size()), 32'd0);
    check("abort_rx_data", 32'(rx_data), 32'd0);
    push_frame(1, 8'h7E, 8'h00, 8'h00, lowt(1, 0));
    exp_rx.push_back(8'h00);
    send(8'h7E, 1'b1);
    wait_done();

    // Second message offered during HOLD of the first.
    @(negedge clk);
    while (!tx_ready) @(negedge clk);
    push_frame(1, 8'h11, 8'h00, 8'h00, lowt(1, 0));
    push_frame(1, 8'h22, 8'h00, 8'h00, lowt(1, 0));
    exp_rx.push_back(8'h00); exp_rx.push_back(8'h00);
    send(8'h11, 1'b1);
    wait_rx();
    fork
      send(8'h22, 1'b1);
      begin
        wait_done();
        hi = 0;
        while (spi_ssel_n && hi < 100) begin
          hi++;
          @(negedge clk);
        end
        // CS_GAP cycles in GAP plus the IDLE cycle in which the byte is taken.
        check("gap_ssel_high", 32'(hi), 32'(CS_GAP + 1));
      end
    join
    wait_done();

    // Loopback: command F5 with two data bytes.
    @(negedge clk);
    push_frame(3, 8'hF5, 8'h11, 8'h22, lowt(3, 0));
    exp_rx.push_back(8'h00); exp_rx.push_back(8'hF5); exp_rx.push_back(8'h11);
    send(8'hF5, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    wait_done();
    check("loopback_cmd", 32'(s_frame.size() > 0 ? s_frame[0] : 8'h00), 32'hF5);
    check("loopback_data_count", 32'(s_frame.size() - 1), 32'd2);

    repeat (10) @(negedge clk);
    check("rx_queue_empty", 32'(exp_rx.size()), 32'd0);
    check("frame_queue_empty", 32'(exp_frames.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
